// File: rtl/tlb_op_unit_if.sv
// TLB entry type and the commit-side request/completion bundle.
// master: commit stage (offers ops); slave: tlb_op_unit.
package tlb_pkg;
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

interface tlb_op_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_invop;
  logic [9:0]  req_asid;
  logic [31:0] req_va;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_op, req_invop,
    output req_asid, req_va,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_op, req_invop,
    input  req_asid, req_va,
    output req_ready, done, err
  );
endinterface

// File: rtl/tlb_op_unit.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between commit and TLB/CSRs.
// Ports: req (tlb_op_if.slave), CSR inputs/update strobes, TLB search/read/write.
module tlb_op_unit
  import tlb_pkg::*;
#(
  parameter int TLBNUM   = 16,
  parameter int TLBIDLEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  tlb_op_if.slave             req,
  input  tlb_entry_t          csr_tlb_rdata,
  input  logic [TLBIDLEN-1:0] csr_tlbidx,
  input  logic [9:0]          csr_asid,
  output logic                csr_tlbsrch_we,
  output logic                csr_tlbsrch_found,
  output logic [TLBIDLEN-1:0] csr_tlbsrch_index,
  output logic                csr_tlb_we,
  output tlb_entry_t          csr_tlb_wdata,
  output logic [18:0]         s_vppn,
  output logic [9:0]          s_asid,
  input  logic                s_found,
  input  logic [TLBIDLEN-1:0] s_index,
  output logic [TLBIDLEN-1:0] tlb_r_index,
  input  tlb_entry_t          tlb_r_entry,
  output logic                tlb_we,
  output logic [TLBIDLEN-1:0] tlb_w_index,
  output tlb_entry_t          tlb_w_entry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_INV  = 2'd2;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [TLBIDLEN-1:0] LAST =
    TLBIDLEN'(TLBNUM - 1);

  logic [1:0]          state;
  logic [2:0]          op_q;
  logic [4:0]          invop_q;
  logic [9:0]          asid_q;
  logic [18:0]         va_q;
  logic                bad_q;
  logic [TLBIDLEN-1:0] fill_ctr;
  logic [TLBIDLEN-1:0] fill_idx;
  logic [TLBIDLEN-1:0] scan_idx;

  logic accept;
  logic bad_req;
  logic va_hit;
  logic asid_eq;
  logic inv_hit;

  assign req.req_ready = (state == S_IDLE) && !reset;
  assign accept  = req.req_valid && req.req_ready;
  assign bad_req = (req.req_op > OP_INV) ||
    ((req.req_op == OP_INV) && (req.req_invop > 5'd6));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      invop_q  <= '0;
      asid_q   <= '0;
      va_q     <= '0;
      bad_q    <= 1'b0;
      fill_ctr <= '0;
      fill_idx <= '0;
      scan_idx <= '0;
    end else begin
      fill_ctr <= fill_ctr + TLBIDLEN'(1);
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= req.req_op;
            invop_q  <= req.req_invop;
            asid_q   <= req.req_asid;
            va_q     <= req.req_va[31:13];
            bad_q    <= bad_req;
            fill_idx <= fill_ctr;
            scan_idx <= '0;
            if (req.req_op == OP_INV && !bad_req)
              state <= S_INV;
            else
              state <= S_EXEC;
          end
        end
        S_EXEC: state <= S_IDLE;
        S_INV: begin
          scan_idx <= scan_idx + TLBIDLEN'(1);
          if (scan_idx == LAST)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Huge pages (ps=21) only compare the top 10 VPPN bits.
  always_comb begin
    va_hit = 1'b0;
    if (tlb_r_entry.ps == 6'd12)
      va_hit = tlb_r_entry.vppn == va_q;
    else if (tlb_r_entry.ps == 6'd21)
      va_hit = tlb_r_entry.vppn[18:9] == va_q[18:9];
  end

  assign asid_eq = tlb_r_entry.asid == asid_q;

  always_comb begin
    inv_hit = 1'b0;
    case (invop_q)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2: inv_hit = tlb_r_entry.g;
      5'd3: inv_hit = !tlb_r_entry.g;
      5'd4: inv_hit = !tlb_r_entry.g && asid_eq;
      5'd5: inv_hit = !tlb_r_entry.g && asid_eq &&
                      va_hit;
      5'd6: inv_hit = (tlb_r_entry.g || asid_eq) &&
                      va_hit;
      default: inv_hit = 1'b0;
    endcase
  end

  always_comb begin
    req.done          = 1'b0;
    req.err           = 1'b0;
    csr_tlbsrch_we    = 1'b0;
    csr_tlb_we        = 1'b0;
    tlb_we            = 1'b0;
    s_vppn            = csr_tlb_rdata.vppn;
    s_asid            = csr_asid;
    csr_tlbsrch_found = s_found;
    csr_tlbsrch_index = s_index;
    csr_tlb_wdata     = tlb_r_entry;
    tlb_r_index       = csr_tlbidx;
    tlb_w_index       = csr_tlbidx;
    tlb_w_entry       = csr_tlb_rdata;
    if (state == S_INV) begin
      tlb_r_index   = scan_idx;
      tlb_w_index   = scan_idx;
      tlb_w_entry   = tlb_r_entry;
      tlb_w_entry.e = 1'b0;
    end
    if (state == S_EXEC && op_q == OP_FILL)
      tlb_w_index = fill_idx;
    // Strobes are gated by reset so an abort takes effect in its own cycle.
    if (!reset) begin
      unique case (1'b1)
        state == S_EXEC: begin
          req.done = 1'b1;
          req.err  = bad_q;
          if (!bad_q) begin
            unique case (1'b1)
              op_q == OP_SRCH: csr_tlbsrch_we = 1'b1;
              op_q == OP_RD:   csr_tlb_we     = 1'b1;
              op_q == OP_WR:   tlb_we         = 1'b1;
              op_q == OP_FILL: tlb_we         = 1'b1;
              default: ;
            endcase
          end
        end
        state == S_INV: begin
          tlb_we   = tlb_r_entry.e && inv_hit;
          req.done = scan_idx == LAST;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with a behavioural 16-entry TLB array.
// Drives at the falling edge and samples 1 time unit later.
module tb_tlb_op_unit;
  import tlb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  tlb_entry_t csr_tlb_rdata;
  logic [3:0] csr_tlbidx;
  logic [9:0] csr_asid;
  logic       csr_tlbsrch_we;
  logic       csr_tlbsrch_found;
  logic [3:0] csr_tlbsrch_index;
  logic       csr_tlb_we;
  tlb_entry_t csr_tlb_wdata;
  logic [18:0] s_vppn;
  logic [9:0] s_asid;
  logic       s_found;
  logic [3:0] s_index;
  logic [3:0] tlb_r_index;
  tlb_entry_t tlb_r_entry;
  logic       tlb_we;
  logic [3:0] tlb_w_index;
  tlb_entry_t tlb_w_entry;

  tlb_entry_t arr [16];
  logic       ld = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] ld_idx = '0;
  tlb_entry_t ld_val = '0;
  logic [3:0] fcnt;

  int tests = 0;
  int fails = 0;

  tlb_op_if bus ();

  tlb_op_unit #(.TLBNUM(16), .TLBIDLEN(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(bus),
    .csr_tlb_rdata(csr_tlb_rdata),
    .csr_tlbidx(csr_tlbidx),
    .csr_asid(csr_asid),
    .csr_tlbsrch_we(csr_tlbsrch_we),
    .csr_tlbsrch_found(csr_tlbsrch_found),
    .csr_tlbsrch_index(csr_tlbsrch_index),
    .csr_tlb_we(csr_tlb_we),
    .csr_tlb_wdata(csr_tlb_wdata),
    .s_vppn(s_vppn),
    .s_asid(s_asid),
    .s_found(s_found),
    .s_index(s_index),
    .tlb_r_index(tlb_r_index),
    .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we),
    .tlb_w_index(tlb_w_index),
    .tlb_w_entry(tlb_w_entry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) arr[i] <= '0;
    end else begin
      if (ld) arr[ld_idx] <= ld_val;
      if (tlb_we) arr[tlb_w_index] <= tlb_w_entry;
    end
  end

  // Expected fill counter: held at 0 in reset, +1 per cycle.
  always @(posedge clk)
    fcnt <= reset ? 4'd0 : fcnt + 4'd1;

  assign tlb_r_entry = arr[tlb_r_index];

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = 0; i < 16; i++)
      if (arr[i].e && arr[i].vppn == s_vppn &&
          (arr[i].g || arr[i].asid == s_asid)) begin
        s_found = 1'b1;
        s_index = i[3:0];
      end
  end

  function automatic tlb_entry_t mk(
    input logic [18:0] vppn, input logic [5:0] ps,
    input logic g, input logic [9:0] asid, input logic e);
    tlb_entry_t t;
    t = '0;
    t.vppn = vppn; t.ps = ps; t.g = g;
    t.asid = asid; t.e = e; t.ppn0 = 20'h1234;
    return t;
  endfunction

  task automatic load(input int idx, input tlb_entry_t v);
    @(negedge clk);
    ld = 1'b1; ld_idx = idx[3:0]; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic clear_arr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Caller is at the falling edge of cycle T; offers the op in T.
  task automatic issue(input logic [2:0] op, input logic [4:0] iv,
                       input logic [9:0] as, input logic [31:0] va);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_invop = iv;
    bus.req_asid = as; bus.req_va = va;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL issue_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({bus.req_ready, bus.done, bus.err, tlb_we, csr_tlb_we, csr_tlbsrch_we} !== 6'b0) begin
      fails++; $display("FAIL reset_outs got %b want 000000",
        {bus.req_ready, bus.done, bus.err, tlb_we, csr_tlb_we, csr_tlbsrch_we});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_wr_rd();
    csr_tlbidx = 4'd5;
    csr_tlb_rdata = mk(19'h12345, 6'd12, 1'b0, 10'd1, 1'b1);
    @(negedge clk);
    issue(3'd2, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({tlb_we, tlb_w_index, tlb_w_entry.vppn, bus.done, bus.err, csr_tlb_we}
        !== {1'b1, 4'd5, 19'h12345, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL wr we=%b idx=%0d vppn=%h done=%b err=%b want 1 5 12345 1 0",
        tlb_we, tlb_w_index, tlb_w_entry.vppn, bus.done, bus.err);
    end
    tests++;
    if (bus.req_ready !== 1'b0) begin
      fails++; $display("FAIL wr_busy_ready got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    issue(3'd1, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({csr_tlb_we, csr_tlb_wdata.vppn, csr_tlb_wdata.e, tlb_we, bus.done}
        !== {1'b1, 19'h12345, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL rd we=%b vppn=%h e=%b twe=%b done=%b want 1 12345 1 0 1",
        csr_tlb_we, csr_tlb_wdata.vppn, csr_tlb_wdata.e, tlb_we, bus.done);
    end
    load(6, mk(19'h00007, 6'd12, 1'b0, 10'd2, 1'b0));
    csr_tlbidx = 4'd6;
    @(negedge clk);
    issue(3'd1, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({csr_tlb_we, csr_tlb_wdata.vppn, csr_tlb_wdata.e} !== {1'b1, 19'h7, 1'b0}) begin
      fails++; $display("FAIL rd_invalid we=%b vppn=%h e=%b want 1 7 0",
        csr_tlb_we, csr_tlb_wdata.vppn, csr_tlb_wdata.e);
    end
  endtask

  task automatic test_srch();
    load(9, mk(19'h00ABC, 6'd12, 1'b0, 10'd3, 1'b1));
    csr_tlb_rdata = mk(19'h00ABC, 6'd12, 1'b0, 10'd0, 1'b0);
    csr_asid = 10'd3;
    @(negedge clk);
    issue(3'd0, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({csr_tlbsrch_we, csr_tlbsrch_found, csr_tlbsrch_index, tlb_we}
        !== {1'b1, 1'b1, 4'd9, 1'b0}) begin
      fails++; $display("FAIL srch_hit we=%b found=%b idx=%0d want 1 1 9",
        csr_tlbsrch_we, csr_tlbsrch_found, csr_tlbsrch_index);
    end
    csr_asid = 10'd4;
    @(negedge clk);
    issue(3'd0, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({csr_tlbsrch_we, csr_tlbsrch_found} !== 2'b10) begin
      fails++; $display("FAIL srch_miss we=%b found=%b want 1 0",
        csr_tlbsrch_we, csr_tlbsrch_found);
    end
  endtask

  task automatic test_fill();
    int n;
    n = 0;
    csr_tlb_rdata = mk(19'h00055, 6'd12, 1'b1, 10'd0, 1'b1);
    @(negedge clk);
    while (fcnt !== 4'd15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (fcnt !== 4'd15) begin
      fails++; $display("FAIL fill_wait timeout fcnt=%0d want 15", fcnt);
    end
    issue(3'd3, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({tlb_we, tlb_w_index, bus.done} !== {1'b1, 4'd15, 1'b1}) begin
      fails++; $display("FAIL fill_15 we=%b idx=%0d done=%b want 1 15 1",
        tlb_we, tlb_w_index, bus.done);
    end
    @(negedge clk);
    issue(3'd3, 5'd0, 10'd0, 32'd0);
    next_cycle();
    tests++;
    if ({tlb_we, tlb_w_index, tlb_w_entry.vppn} !== {1'b1, 4'd1, 19'h55}) begin
      fails++; $display("FAIL fill_wrap we=%b idx=%0d vppn=%h want 1 1 55",
        tlb_we, tlb_w_index, tlb_w_entry.vppn);
    end
  endtask

  task automatic test_inv5();
    int wcnt;
    logic [3:0] widx;
    logic we_e;
    wcnt = 0; widx = '0; we_e = 1'b1;
    clear_arr();
    load(2, mk(19'h00200, 6'd21, 1'b0, 10'd7, 1'b1));
    load(3, mk(19'h00200, 6'd21, 1'b1, 10'd7, 1'b1));
    load(4, mk(19'h00200, 6'd21, 1'b0, 10'd8, 1'b1));
    load(5, mk(19'h00201, 6'd12, 1'b0, 10'd7, 1'b1));
    @(negedge clk);
    issue(3'd4, 5'd5, 10'd7, 32'h0040_0000);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      // Keep offering a WR while busy; it must be ignored.
      bus.req_valid = (k < 15);
      bus.req_op = 3'd2;
      #1;
      if (tlb_we) begin
        wcnt++; widx = tlb_w_index; we_e = tlb_w_entry.e;
      end
      if (k == 8) begin
        tests++;
        if (bus.req_ready !== 1'b0) begin
          fails++; $display("FAIL inv_busy_ready got %b want 0", bus.req_ready);
        end
      end
      if (k == 15) begin
        tests++;
        if (bus.done !== 1'b0) begin
          fails++; $display("FAIL inv_early_done got %b want 0", bus.done);
        end
      end
      if (k == 16) begin
        tests++;
        if ({bus.done, bus.err} !== 2'b10) begin
          fails++; $display("FAIL inv_done done=%b err=%b want 1 0", bus.done, bus.err);
        end
      end
    end
    tests++;
    if (wcnt !== 1 || widx !== 4'd2 || we_e !== 1'b0) begin
      fails++; $display("FAIL inv5_writes cnt=%0d idx=%0d e=%b want 1 2 0", wcnt, widx, we_e);
    end
    @(negedge clk);
    #1;
    tests++;
    if ({tlb_we, bus.done, arr[2].e, arr[3].e, arr[4].e} !== 5'b00011) begin
      fails++; $display("FAIL inv5_after we=%b done=%b e2=%b e3=%b e4=%b want 0 0 0 1 1",
        tlb_we, bus.done, arr[2].e, arr[3].e, arr[4].e);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [2];
    logic [4:0] ivs [2];
    ops[0] = 3'd4; ivs[0] = 5'd7;
    ops[1] = 3'd6; ivs[1] = 5'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(ops[i], ivs[i], 10'd0, 32'd0);
      next_cycle();
      tests++;
      if ({bus.done, bus.err, tlb_we, csr_tlb_we, csr_tlbsrch_we} !== 5'b11000) begin
        fails++; $display("FAIL illegal_%0d done=%b err=%b we=%b%b%b want 1 1 000", i,
          bus.done, bus.err, tlb_we, csr_tlb_we, csr_tlbsrch_we);
      end
    end
  endtask

  task automatic test_reset_abort();
    int wcnt;
    logic dseen;
    wcnt = 0; dseen = 1'b0;
    clear_arr();
    for (int i = 0; i < 6; i++)
      load(i, mk(19'(i), 6'd12, 1'b0, 10'd1, 1'b1));
    @(negedge clk);
    issue(3'd4, 5'd0, 10'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (k == 4) reset = 1'b1;
      if (k == 7) reset = 1'b0;
      #1;
      if (tlb_we) wcnt++;
      if (bus.done) dseen = 1'b1;
      if (k == 4) begin
        tests++;
        if ({tlb_we, bus.done, bus.req_ready} !== 3'b000) begin
          fails++; $display("FAIL abort_cycle we=%b done=%b ready=%b want 000",
            tlb_we, bus.done, bus.req_ready);
        end
      end
    end
    tests++;
    if (wcnt !== 3 || dseen !== 1'b0) begin
      fails++; $display("FAIL abort_writes cnt=%0d done_seen=%b want 3 0", wcnt, dseen);
    end
    tests++;
    if ({bus.req_ready, arr[3].e, arr[2].e} !== 3'b110) begin
      fails++; $display("FAIL abort_after ready=%b e3=%b e2=%b want 1 1 0",
        bus.req_ready, arr[3].e, arr[2].e);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_invop = '0;
    bus.req_asid = '0; bus.req_va = '0;
    csr_tlb_rdata = '0; csr_tlbidx = '0; csr_asid = '0;
    for (int i = 0; i < 16; i++) arr[i] = '0;
    test_reset();
    test_wr_rd();
    test_srch();
    test_fill();
    test_inv5();
    test_illegal();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/tlb_op_unit.md
# tlb_op_unit

Multi-cycle sequencer for the TLB-maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB). It sits between the commit stage and the TLB array / CSR file. It takes one operation at a time from commit and reads TLBEHI/TLBIDX/TLBELO/ASID state from the CSR file. It drives the CSR file's `csr_tlbsrch_*` and `csr_tlb_we/wdata` update ports and the TLB array's read, write and search ports.

## Interface
Parameters:
- `TLBNUM`, 16: number of TLB entries, always a power of two.
- `TLBIDLEN`, 4: index width, equal to log2(`TLBNUM`).

Ports. The clock is `clk`. `reset` is synchronous and active-high. `tlb_entry_t` is the codebase's packed entry type with fields vppn, ps, g, asid, e, ppn0/1, plv0/1, mat0/1, d0/1, v0/1.
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `req_valid` in 1: an operation is offered.
- `req_ready` out 1: accepts an operation; high only in IDLE.
- `req_op` in 3: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 are illegal.
- `req_invop` in 5: INVTLB op code.
- `req_asid` in 10: ASID operand for INVTLB (rj).
- `req_va` in 32: VA operand for INVTLB (rk).
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; set for an illegal `req_op` or an INVTLB op code above 6.
- `csr_tlb_rdata` in tlb_entry_t: entry assembled from CSRs.
- `csr_tlbidx` in TLBIDLEN: TLBIDX.Index.
- `csr_asid` in 10: ASID.ASID.
- `csr_tlbsrch_we` out 1: TLBSRCH result write to CSRs.
- `csr_tlbsrch_found` out 1: TLBSRCH hit.
- `csr_tlbsrch_index` out TLBIDLEN: TLBSRCH hit index.
- `csr_tlb_we` out 1: TLBRD result write to CSRs.
- `csr_tlb_wdata` out tlb_entry_t: TLBRD result entry.
- `s_vppn` out 19: search key VPPN.
- `s_asid` out 10: search key ASID.
- `s_found` in 1: search hit (combinational).
- `s_index` in TLBIDLEN: search hit index (combinational).
- `tlb_r_index` out TLBIDLEN: array read address.
- `tlb_r_entry` in tlb_entry_t: array read data (combinational).
- `tlb_we` out 1: array write enable.
- `tlb_w_index` out TLBIDLEN: array write address.
- `tlb_w_entry` out tlb_entry_t: array write data.

## Operation
- States: IDLE, EXEC, INV_SCAN.
- Accept happens on `req_valid && req_ready`. On accept, latch op, invop, asid and va, and latch `fill_idx`.
  - SRCH/RD/WR/FILL go to EXEC.
  - INV with invop ≤ 6 goes to INV_SCAN with `scan_idx`=0.
  - Illegal op or invop goes to EXEC and finishes with `err`=1 and no writes.
- EXEC lasts exactly one cycle, then returns to IDLE. `done` pulses in that cycle.
  - SRCH: `s_vppn`=`csr_tlb_rdata.vppn`, `s_asid`=`csr_asid`. Pulse `csr_tlbsrch_we`, with found/index taken from `s_found`/`s_index`.
  - RD: `tlb_r_index`=`csr_tlbidx`. Pulse `csr_tlb_we` with `csr_tlb_wdata`=`tlb_r_entry`, passed unchanged including e=0.
  - WR: pulse `tlb_we`, with `tlb_w_index`=`csr_tlbidx` and `tlb_w_entry`=`csr_tlb_rdata`.
  - FILL: same as WR, but the index is the latched `fill_idx`.
- `fill_ctr` is a free-running TLBIDLEN-bit counter. It increments every cycle and wraps from TLBNUM-1 to 0.
- INV_SCAN reads entry `scan_idx` each cycle via `tlb_r_index`.
  - If the entry has e=1 and matches, pulse `tlb_we` in the same cycle. The write goes to the same index with the entry unchanged except e=0.
  - `scan_idx` increments each cycle. When `scan_idx`=TLBNUM-1, pulse `done` and return to IDLE.
- INVTLB match rules:
  - 0, 1: all entries.
  - 2: g=1.
  - 3: g=0.
  - 4: g=0 and asid==req_asid.
  - 5: g=0, asid==req_asid and VA match.
  - 6: (g=1 or asid==req_asid) and VA match.
- VA match: for ps=12, compare vppn with `req_va[31:13]`. For ps=21, compare vppn[18:9] with `req_va[31:22]` only.
- In all other cycles every write strobe is 0. Data outputs are don't-care.

## Timing
- Reset values: state IDLE, `done`=0, `err`=0, `csr_tlbsrch_we`=0, `csr_tlb_we`=0, `tlb_we`=0, `fill_ctr`=0, `scan_idx`=0.
- `req_ready` is 0 during reset and 1 in the first cycle after reset deasserts.
- Accept happens at cycle T. SRCH/RD/WR/FILL/illegal operations perform their writes and `done` at T+1.
- INV runs from T+1 to T+TLBNUM, with `done` at T+TLBNUM.
- The next accept is possible at the cycle following `done`. There are no back-to-back accepts.
- Search, read and CSR inputs are sampled combinationally in the write cycle. The caller holds CSRs stable while `req_ready`=0.
- Reset mid-INV aborts immediately: no further `tlb_we`, and no `done` is emitted.
- `req_valid` while busy is ignored and not queued.

## Test plan
- TLBWR with `csr_tlbidx`=5 and `csr_tlb_rdata`.vppn=0x12345, e=1 → `tlb_we`=1 at T+1, index 5, `done` at T+1. A following TLBRD of index 5 → `csr_tlb_we` with vppn=0x12345.
- TLBSRCH with the array holding vppn=0x00ABC, asid=3 at index 9, `csr_asid`=3 → `csr_tlbsrch_found`=1, index 9. Changing the asid to 4 → found=0.
- TLBFILL accepted at cycle T with `fill_ctr`=15 → write to index 15. The next FILL, two cycles later, writes index 1, confirming wrap-around.
- INVTLB op 5 with asid=7 and VA=0x00400000, over entries ps=21 vppn=0x00200 g=0 asid=7 (clear) and g=1 (keep) → exactly one `tlb_we`, with e=0. `done` at T+16.
- INVTLB op 7 → `done`=1, `err`=1 at T+1, no `tlb_we`. `req_op`=6 gives the same result.
- INVTLB op 0 with reset asserted at T+4 → `tlb_we` only at T+1..T+3. `done` never pulses. `req_ready`=1 after reset.
